mem_port_arbiter: RTL and testbench

- Shares one single-port 2048x32 SRAM macro between three requesters:
  - the boot program loader
  - the pipeline's MEM-stage data access
  - the IF-stage instruction fetch
- This lets the core run from one unified memory instead of separate instruction and data macros.
- Issues at most one SRAM access per cycle and routes read data back to the owner one cycle later.
- Drives stall requests into the hazard logic when a requester is denied.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_arb_prio.sv | 31 +++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// FSM states, read-owner tags and the SRAM geometry.
package mem_arb_pkg;

    localparam int SRAM_WORDS = 2048;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        BOOT = 2'd1,
        RUN  = 2'd2
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, SRAM and debug bundle of the memory port arbiter.
// slave = arbiter side, master = requesters/SRAM side.
interface mem_port_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 11
);
    logic              boot_en;
    logic              ldr_req;
    logic [WIDTH-1:0]  ldr_addr;
    logic [WIDTH-1:0]  ldr_wdata;
    logic              ldr_done;
    logic              ldr_gnt;
    logic              if_req;
    logic [WIDTH-1:0]  if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [WIDTH-1:0]  if_rdata;
    logic              if_stall;
    logic              dm_req;
    logic              dm_we;
    logic [WIDTH-1:0]  dm_addr;
    logic [WIDTH-1:0]  dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [WIDTH-1:0]  dm_rdata;
    logic              dm_stall;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [WIDTH-1:0]  sram_d;
    logic [WIDTH-1:0]  sram_q;
    logic [1:0]        state_o;

    modport slave (
        input  boot_en, ldr_req, ldr_addr, ldr_wdata, ldr_done,
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  sram_q,
        output ldr_gnt,
        output if_gnt, if_rvalid, if_rdata, if_stall,
        output dm_gnt, dm_rvalid, dm_rdata, dm_stall,
        output sram_cen, sram_wen, sram_a, sram_d,
        output state_o
    );

    modport master (
        output boot_en, ldr_req, ldr_addr, ldr_wdata, ldr_done,
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output sram_q,
        input  ldr_gnt,
        input  if_gnt, if_rvalid, if_rdata, if_stall,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_stall,
        input  sram_cen, sram_wen, sram_a, sram_d,
        input  state_o
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Combinational grant logic: loader-only in BOOT,
// data over fetch in RUN unless fetch is starving.
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  mem_arb_state_t state,
    input  logic           ldr_req,
    input  logic           if_req,
    input  logic           dm_req,
    input  logic           starve,
    output logic           ldr_gnt,
    output logic           if_gnt,
    output logic           dm_gnt
);

    always_comb begin
        ldr_gnt = 1'b0;
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        unique case (1'b1)
            (state == BOOT): ldr_gnt = ldr_req;
            (state == RUN && starve && if_req): if_gnt = 1'b1;
            (state == RUN && !(starve && if_req)): begin
                dm_gnt = dm_req;
                if_gnt = if_req & ~dm_req;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter for loader, MEM-stage data and IF fetch.
// Holds the boot FSM, fetch starvation counter and read-owner tag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = $clog2(SRAM_WORDS),
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    mem_arb_state_t   state_q;
    mem_owner_t       owner_q;
    logic [SW-1:0]    starve_q;
    logic             ldr_gnt;
    logic             if_gnt;
    logic             dm_gnt;
    logic [WIDTH-1:0] g_addr;
    logic [WIDTH-1:0] g_wdata;
    logic             unused_addr;

    mem_arb_prio u_prio (
        .state   (state_q),
        .ldr_req (bus.ldr_req),
        .if_req  (bus.if_req),
        .dm_req  (bus.dm_req),
        .starve  (starve_q == STARVE_LIM),
        .ldr_gnt (ldr_gnt),
        .if_gnt  (if_gnt),
        .dm_gnt  (dm_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= HOLD;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            unique case (state_q)
                HOLD:    state_q <= bus.boot_en ? BOOT : RUN;
                BOOT:    if (bus.ldr_done) state_q <= RUN;
                default: ;
            endcase

            if (state_q != RUN || !bus.if_req || if_gnt)
                starve_q <= '0;
            else if (starve_q != STARVE_LIM)
                starve_q <= starve_q + SW'(1);

            // Tag tells the return path whose read sram_q carries next cycle.
            unique case (1'b1)
                if_gnt:                 owner_q <= OWN_IF;
                (dm_gnt && !bus.dm_we): owner_q <= OWN_DM;
                default:                owner_q <= OWN_NONE;
            endcase
        end
    end

    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        unique case (1'b1)
            ldr_gnt: begin
                g_addr  = bus.ldr_addr;
                g_wdata = bus.ldr_wdata;
            end
            dm_gnt: begin
                g_addr  = bus.dm_addr;
                g_wdata = bus.dm_we ? bus.dm_wdata : '0;
            end
            if_gnt:  g_addr = bus.if_addr;
            default: ;
        endcase
    end

    // Byte offset and bits above the macro wrap away.
    assign unused_addr = ^{g_addr[WIDTH-1:ADDR_W+2], g_addr[1:0]};

    assign bus.sram_cen  = ~(ldr_gnt | if_gnt | dm_gnt);
    assign bus.sram_wen  = ~(ldr_gnt | (dm_gnt & bus.dm_we));
    assign bus.sram_a    = g_addr[ADDR_W+1:2];
    assign bus.sram_d    = g_wdata;

    assign bus.ldr_gnt   = ldr_gnt;
    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.if_stall  = bus.if_req & ~if_gnt;
    assign bus.dm_stall  = bus.dm_req & ~dm_gnt;
    assign bus.if_rvalid = (owner_q == OWN_IF);
    assign bus.dm_rvalid = (owner_q == OWN_DM);
    assign bus.if_rdata  = bus.sram_q;
    assign bus.dm_rdata  = bus.sram_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter with SRAM model
// and a rule-level reference of grants, starvation and memory contents.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] mem     [0:2047] = '{default: '0};
    logic [31:0] ref_mem [0:2047] = '{default: '0};

    mem_port_arbiter_if #(.WIDTH(32), .ADDR_W(11)) bus ();

    mem_port_arbiter #(.WIDTH(32), .ADDR_W(11), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_wen) mem[bus.sram_a] <= bus.sram_d;
            else               bus.sram_q <= mem[bus.sram_a];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [10:0] widx(input logic [31:0] a);
        return a[12:2];
    endfunction

    initial begin
        int          m_starve;
        int          pend;
        logic [31:0] pend_data;
        logic        ir, dr, we, e_if, e_dm;
        logic [31:0] ia, da, wd, ea;

        rst           = 1'b0;
        bus.boot_en   = 1'b1;
        bus.ldr_req   = 1'b0;
        bus.ldr_addr  = '0;
        bus.ldr_wdata = '0;
        bus.ldr_done  = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h10;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.sram_q    = '0;

        // reset state
        repeat (2) tick();
        mid();
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk1("rst_cen", bus.sram_cen, 1'b1);
        chk1("rst_wen", bus.sram_wen, 1'b1);
        chk("rst_a", 32'(bus.sram_a), 32'd0);
        chk("rst_d", bus.sram_d, 32'd0);
        chk1("rst_if_gnt", bus.if_gnt, 1'b0);
        chk1("rst_if_stall", bus.if_stall, 1'b1);
        chk1("rst_if_rvalid", bus.if_rvalid, 1'b0);
        chk1("rst_dm_rvalid", bus.dm_rvalid, 1'b0);
        chk1("rst_ldr_gnt", bus.ldr_gnt, 1'b0);

        tick();
        rst        = 1'b1;
        bus.if_req = 1'b0;
        mid();
        chk("hold_after_release", 32'(bus.state_o), 32'd0);
        tick();

        // boot load with concurrent fetch
        bus.ldr_req   = 1'b1;
        bus.ldr_addr  = 32'h10;
        bus.ldr_wdata = 32'hDEADBEEF;
        bus.if_req    = 1'b1;
        mid();
        chk("boot_state", 32'(bus.state_o), 32'd1);
        chk1("boot_ldr_gnt", bus.ldr_gnt, 1'b1);
        chk("boot_a", 32'(bus.sram_a), 32'd4);
        chk1("boot_wen", bus.sram_wen, 1'b0);
        chk1("boot_cen", bus.sram_cen, 1'b0);
        chk("boot_d", bus.sram_d, 32'hDEADBEEF);
        chk1("boot_if_stall", bus.if_stall, 1'b1);
        chk1("boot_if_gnt", bus.if_gnt, 1'b0);
        ref_mem[4] = 32'hDEADBEEF;
        tick();

        // last write coincides with ldr_done
        bus.if_req    = 1'b0;
        bus.ldr_addr  = 32'h14;
        bus.ldr_wdata = 32'hCAFEF00D;
        bus.ldr_done  = 1'b1;
        mid();
        chk1("done_ldr_gnt", bus.ldr_gnt, 1'b1);
        chk("done_state", 32'(bus.state_o), 32'd1);
        ref_mem[5] = 32'hCAFEF00D;
        tick();

        bus.ldr_req  = 1'b0;
        bus.ldr_done = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        mid();
        chk("run_state", 32'(bus.state_o), 32'd2);
        chk1("run_if_gnt", bus.if_gnt, 1'b1);
        chk("run_if_a", 32'(bus.sram_a), 32'd4);
        chk1("run_if_wen", bus.sram_wen, 1'b1);
        tick();

        bus.if_addr = 32'h14;
        mid();
        chk1("b2b_if_rvalid0", bus.if_rvalid, 1'b1);
        chk("b2b_if_rdata0", bus.if_rdata, 32'hDEADBEEF);
        chk1("b2b_if_gnt", bus.if_gnt, 1'b1);
        tick();

        bus.if_req = 1'b0;
        mid();
        chk1("b2b_if_rvalid1", bus.if_rvalid, 1'b1);
        chk("b2b_if_rdata1", bus.if_rdata, 32'hCAFEF00D);
        chk1("b2b_dm_rvalid", bus.dm_rvalid, 1'b0);
        tick();

        // contention: fetch forced through after SMAX denials
        for (int k = 1; k <= 6; k++) begin
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h10;
            bus.dm_req  = 1'b1;
            bus.dm_we   = 1'b0;
            bus.dm_addr = 32'h20;
            mid();
            e_if = (k == SMAX + 1);
            chk1($sformatf("cont%0d_if_gnt", k), bus.if_gnt, e_if);
            chk1($sformatf("cont%0d_dm_gnt", k), bus.dm_gnt, ~e_if);
            chk1($sformatf("cont%0d_if_stall", k), bus.if_stall, ~e_if);
            chk1($sformatf("cont%0d_dm_stall", k), bus.dm_stall, e_if);
            if (k > 1) begin
                chk1($sformatf("cont%0d_if_rv", k), bus.if_rvalid,
                     (k - 1) == SMAX + 1);
                chk1($sformatf("cont%0d_dm_rv", k), bus.dm_rvalid,
                     (k - 1) != SMAX + 1);
            end
            tick();
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        mid();
        chk1("cont_tail_dm_rv", bus.dm_rvalid, 1'b1);
        chk1("cont_tail_if_rv", bus.if_rvalid, 1'b0);
        tick();

        // store at top word, then wrapped load of the same word
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h1FFC;
        bus.dm_wdata = 32'h12345678;
        mid();
        chk1("st_gnt", bus.dm_gnt, 1'b1);
        chk("st_a", 32'(bus.sram_a), 32'h7FF);
        chk1("st_wen", bus.sram_wen, 1'b0);
        chk("st_d", bus.sram_d, 32'h12345678);
        ref_mem[2047] = 32'h12345678;
        tick();

        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h3FFC;
        mid();
        chk("ld_wrap_a", 32'(bus.sram_a), 32'h7FF);
        chk1("ld_wen", bus.sram_wen, 1'b1);
        chk1("st_no_rvalid", bus.dm_rvalid, 1'b0);
        tick();

        bus.dm_req = 1'b0;
        mid();
        chk1("ld_rvalid", bus.dm_rvalid, 1'b1);
        chk("ld_rdata", bus.dm_rdata, 32'h12345678);
        tick();

        // randomized traffic against the rule-level model
        m_starve  = 0;
        pend      = 0;
        pend_data = '0;
        for (int n = 0; n < 400; n++) begin
            ir = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            we = ($urandom_range(0, 3) == 0);
            ia = $urandom;
            da = $urandom;
            wd = $urandom;
            bus.if_req   = ir;
            bus.if_addr  = ia;
            bus.dm_req   = dr;
            bus.dm_we    = we;
            bus.dm_addr  = da;
            bus.dm_wdata = wd;
            mid();

            chk1("rnd_if_rvalid", bus.if_rvalid, pend == 1);
            chk1("rnd_dm_rvalid", bus.dm_rvalid, pend == 2);
            if (pend == 1) chk("rnd_if_rdata", bus.if_rdata, pend_data);
            if (pend == 2) chk("rnd_dm_rdata", bus.dm_rdata, pend_data);

            e_dm = dr && !(m_starve == SMAX && ir);
            e_if = ir && !e_dm;
            chk1("rnd_if_gnt", bus.if_gnt, e_if);
            chk1("rnd_dm_gnt", bus.dm_gnt, e_dm);
            chk1("rnd_if_stall", bus.if_stall, ir && !e_if);
            chk1("rnd_dm_stall", bus.dm_stall, dr && !e_dm);
            chk1("rnd_cen", bus.sram_cen, !(e_if || e_dm));
            chk1("rnd_wen", bus.sram_wen, !(e_dm && we));

            pend = 0;
            if (e_if || e_dm) begin
                ea = e_if ? ia : da;
                chk("rnd_a", 32'(bus.sram_a), 32'(widx(ea)));
                if (e_dm && we) begin
                    chk("rnd_d", bus.sram_d, wd);
                    ref_mem[widx(ea)] = wd;
                end else begin
                    pend      = e_if ? 1 : 2;
                    pend_data = ref_mem[widx(ea)];
                end
            end

            if (!ir || e_if)         m_starve = 0;
            else if (m_starve < SMAX) m_starve++;
            tick();
        end

        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        mid();
        chk1("rnd_tail_if_rv", bus.if_rvalid, pend == 1);
        chk1("rnd_tail_dm_rv", bus.dm_rvalid, pend == 2);
        tick();

        // asynchronous reset in the cycle after a granted fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        mid();
        chk1("mr_if_gnt", bus.if_gnt, 1'b1);
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk1("mr_if_rvalid", bus.if_rvalid, 1'b0);
        chk1("mr_cen", bus.sram_cen, 1'b1);
        chk("mr_state", 32'(bus.state_o), 32'd0);
        chk1("mr_if_gnt_off", bus.if_gnt, 1'b0);
        tick();

        // release with boot_en low goes straight to RUN
        bus.boot_en = 1'b0;
        bus.if_req  = 1'b0;
        tick();
        rst = 1'b1;
        mid();
        chk("nb_hold", 32'(bus.state_o), 32'd0);
        chk1("nb_no_reissue", bus.if_rvalid, 1'b0);
        tick();
        bus.ldr_req   = 1'b1;
        bus.ldr_addr  = 32'h40;
        bus.ldr_wdata = 32'h55AA55AA;
        mid();
        chk("nb_run", 32'(bus.state_o), 32'd2);
        chk1("nb_ldr_gnt", bus.ldr_gnt, 1'b0);
        chk1("nb_cen", bus.sram_cen, 1'b1);
        tick();
        bus.ldr_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
